// File: rtl/cacheline_adapter.sv
// cacheline_adapter
//    Turns one 256-bit cache-line read or write request from the cache
//    arbiter (dfp side) into a 4-beat, 64-bit burst on the bmem port. It also
//    reassembles the returning read beats into a full line. Only one
//    transaction is in flight at a time.
//
// Ports
//    clk_i, rst_i      clock; synchronous active-high reset
//    dfp_addr_i        line address (bits [4:0] ignored)
//    dfp_read_i        line read request, held until dfp_resp_o
//    dfp_write_i       line write request, held until dfp_resp_o (wins over read)
//    dfp_wdata_i       write line, beat k = bits [64k+63:64k]
//    dfp_rdata_o       assembled line, valid while dfp_resp_o = 1
//    dfp_resp_o        one-cycle completion pulse
//    bmem_addr_o       line-aligned burst address
//    bmem_read_o       read request
//    bmem_write_o      write beat valid
//    bmem_wdata_o      current write beat
//    bmem_ready_i      memory accepts read request / current write beat
//    bmem_raddr_i      address tag of returning read beat
//    bmem_rdata_i      returning read beat
//    bmem_rvalid_i     read beat valid
module cacheline_adapter #(
   localparam int LINE_BITS = 256,
   localparam int BEAT_BITS = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [31:0]          dfp_addr_i,
   input  logic                 dfp_read_i,
   input  logic                 dfp_write_i,
   input  logic [LINE_BITS-1:0] dfp_wdata_i,
   output logic [LINE_BITS-1:0] dfp_rdata_o,
   output logic                 dfp_resp_o,
   output logic [31:0]          bmem_addr_o,
   output logic                 bmem_read_o,
   output logic                 bmem_write_o,
   output logic [BEAT_BITS-1:0] bmem_wdata_o,
   input  logic                 bmem_ready_i,
   input  logic [31:0]          bmem_raddr_i,
   input  logic [BEAT_BITS-1:0] bmem_rdata_i,
   input  logic                 bmem_rvalid_i
);

   localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_REQ   = 3'd1,
      S_RD_DATA  = 3'd2,
      S_WR_BURST = 3'd3,
      S_RESP     = 3'd4
   } state_e;

   state_e                 state_q;
   logic [1:0]             cnt_q;
   logic [31:0]            addr_q;
   logic [LINE_BITS-1:0]   line_q;
   logic                   bmem_read_q;
   logic                   bmem_write_q;
   logic [BEAT_BITS-1:0]   bmem_wdata_q;
   logic                   dfp_resp_q;

   logic [1:0]             cnt_d;
   logic                   beat_match_d;
   logic [BEAT_BITS-1:0]   next_wbeat_d;

   // Beat bookkeeping shared by the read and write paths.
   assign cnt_d        = cnt_q + 2'd1;
   assign beat_match_d = bmem_rvalid_i && (bmem_raddr_i == addr_q);
   // The index is {beat, 6'b0} = 64 * beat. It is exactly 8 bits wide for the 256-bit line.
   assign next_wbeat_d = line_q[{cnt_d, 6'd0} +: BEAT_BITS];

   // Control FSM. Every bmem/dfp output is a register updated here, so
   // there is no combinational path from the dfp inputs to the bmem outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         cnt_q        <= 2'd0;
         addr_q       <= 32'd0;
         line_q       <= '0;
         bmem_read_q  <= 1'b0;
         bmem_write_q <= 1'b0;
         bmem_wdata_q <= '0;
         dfp_resp_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               dfp_resp_q <= 1'b0;
               if (dfp_write_i) begin
                  // A write wins over a simultaneous read. The read is not serviced.
                  addr_q       <= dfp_addr_i & LINE_MASK;
                  line_q       <= dfp_wdata_i;
                  cnt_q        <= 2'd0;
                  bmem_write_q <= 1'b1;
                  bmem_wdata_q <= dfp_wdata_i[BEAT_BITS-1:0];
                  state_q      <= S_WR_BURST;
               end else if (dfp_read_i) begin
                  addr_q      <= dfp_addr_i & LINE_MASK;
                  cnt_q       <= 2'd0;
                  bmem_read_q <= 1'b1;
                  state_q     <= S_RD_REQ;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RD_REQ: begin
               if (bmem_ready_i) begin
                  bmem_read_q <= 1'b0;
                  state_q     <= S_RD_DATA;
               end else begin
                  bmem_read_q <= 1'b1;
               end
            end
            S_RD_DATA: begin
               // Beats tagged with another line's address are dropped.
               if (beat_match_d) begin
                  line_q[{cnt_q, 6'd0} +: BEAT_BITS] <= bmem_rdata_i;
                  cnt_q <= cnt_d;
                  if (cnt_q == 2'd3) begin
                     dfp_resp_q <= 1'b1;
                     state_q    <= S_RESP;
                  end else begin
                     state_q <= S_RD_DATA;
                  end
               end else begin
                  state_q <= S_RD_DATA;
               end
            end
            S_WR_BURST: begin
               if (bmem_ready_i) begin
                  cnt_q <= cnt_d;
                  if (cnt_q == 2'd3) begin
                     bmem_write_q <= 1'b0;
                     bmem_wdata_q <= '0;
                     dfp_resp_q   <= 1'b1;
                     state_q      <= S_RESP;
                  end else begin
                     bmem_wdata_q <= next_wbeat_d;
                  end
               end else begin
                  // Backpressure: keep presenting the same beat.
                  bmem_write_q <= 1'b1;
               end
            end
            S_RESP: begin
               dfp_resp_q <= 1'b0;
               state_q    <= S_IDLE;
            end
            default: begin
               state_q      <= S_IDLE;
               cnt_q        <= 2'd0;
               bmem_read_q  <= 1'b0;
               bmem_write_q <= 1'b0;
               dfp_resp_q   <= 1'b0;
            end
         endcase
      end
   end

   assign dfp_rdata_o  = line_q;
   assign dfp_resp_o   = dfp_resp_q;
   assign bmem_addr_o  = addr_q;
   assign bmem_read_o  = bmem_read_q;
   assign bmem_write_o = bmem_write_q;
   assign bmem_wdata_o = bmem_wdata_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter
//    Directed stimulus with a scoreboard. The stimulus process pushes the
//    expected bmem activity and dfp responses into queues. A negedge monitor
//    pops each queue entry and compares it whenever the DUT presents an output.
module tb_cacheline_adapter;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   dfp_addr;
   logic          dfp_read;
   logic          dfp_write;
   logic [255:0]  dfp_wdata;
   logic [255:0]  dfp_rdata_o;
   logic          dfp_resp_o;
   logic [31:0]   bmem_addr_o;
   logic          bmem_read_o;
   logic          bmem_write_o;
   logic [63:0]   bmem_wdata_o;
   logic          bmem_ready;
   logic [31:0]   bmem_raddr;
   logic [63:0]   bmem_rdata;
   logic          bmem_rvalid;

   typedef struct { logic [255:0] line; int cyc; } resp_t;
   typedef struct { logic [31:0] addr; logic [63:0] data; } wbeat_t;

   resp_t         sb_q[$];
   wbeat_t        wexp_q[$];
   logic [31:0]   rdaddr_q[$];

   int            cyc = 0;
   int            checks = 0;
   int            failures = 0;
   logic [63:0]   mem_beats [4];
   logic [1:0]    mem_idx = 2'd0;

   cacheline_adapter dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .dfp_addr_i   (dfp_addr),
      .dfp_read_i   (dfp_read),
      .dfp_write_i  (dfp_write),
      .dfp_wdata_i  (dfp_wdata),
      .dfp_rdata_o  (dfp_rdata_o),
      .dfp_resp_o   (dfp_resp_o),
      .bmem_addr_o  (bmem_addr_o),
      .bmem_read_o  (bmem_read_o),
      .bmem_write_o (bmem_write_o),
      .bmem_wdata_o (bmem_wdata_o),
      .bmem_ready_i (bmem_ready),
      .bmem_raddr_i (bmem_raddr),
      .bmem_rdata_i (bmem_rdata),
      .bmem_rvalid_i(bmem_rvalid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_event(input string name);
      checks++;
      failures++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input logic v, input logic [31:0] a, input logic [63:0] d);
      bmem_rvalid = v;
      bmem_raddr  = a;
      bmem_rdata  = d;
   endtask

   // Monitor: compares every presented output against the scoreboard queues.
   always @(negedge clk) begin
      if (bmem_read_o && bmem_write_o) fail_event("read_and_write_both_high");
      if (bmem_read_o) begin
         if (rdaddr_q.size() == 0) fail_event("unexpected_bmem_read");
         else check("bmem_read_addr", 256'(bmem_addr_o), 256'(rdaddr_q.pop_front()));
      end
      if (bmem_write_o) begin
         if (wexp_q.size() == 0) fail_event("unexpected_bmem_write");
         else begin
            wbeat_t w;
            w = wexp_q.pop_front();
            check("bmem_write_addr", 256'(bmem_addr_o), 256'(w.addr));
            check("bmem_wdata", 256'(bmem_wdata_o), 256'(w.data));
         end
         // Memory model: store each accepted beat of the current burst.
         if (bmem_ready) begin
            mem_beats[mem_idx] = bmem_wdata_o;
            mem_idx = mem_idx + 2'd1;
         end
      end else begin
         mem_idx = 2'd0;
      end
      if (dfp_resp_o) begin
         if (sb_q.size() == 0) fail_event("unexpected_dfp_resp");
         else begin
            resp_t e;
            e = sb_q.pop_front();
            check("resp_rdata", dfp_rdata_o, e.line);
            check("resp_cycle", 256'(cyc), 256'(e.cyc));
         end
      end
   end

   // Wait (bounded) for the resp pulse. Then drop the request and confirm that the pulse lasted one cycle.
   task automatic wait_resp(input int budget);
      int n = 0;
      while (!dfp_resp_o && n < budget) begin
         tick;
         n++;
      end
      if (!dfp_resp_o) fail_event("resp_timeout");
      dfp_read    = 1'b0;
      dfp_write   = 1'b0;
      bmem_rvalid = 1'b0;
      tick;
      check("resp_one_cycle", 256'(dfp_resp_o), 256'(1'b0));
   endtask

   task automatic read_min(input logic [31:0] a, input logic [255:0] beats, input logic [255:0] exp);
      int c0;
      c0 = cyc;
      dfp_addr   = a;
      dfp_read   = 1'b1;
      bmem_ready = 1'b1;
      sb_q.push_back('{exp, c0 + 6});
      rdaddr_q.push_back(a & 32'hFFFF_FFE0);
      tick;
      for (int k = 0; k < 4; k++) begin
         tick;
         drive_beat(1'b1, a & 32'hFFFF_FFE0, beats[64*k +: 64]);
      end
      tick;
      drive_beat(1'b0, 32'd0, 64'd0);
      wait_resp(20);
   endtask

   task automatic write_full(input logic [31:0] a, input logic [255:0] w, input logic also_read);
      int c0;
      c0 = cyc;
      dfp_addr   = a;
      dfp_wdata  = w;
      dfp_write  = 1'b1;
      dfp_read   = also_read;
      bmem_ready = 1'b1;
      for (int k = 0; k < 4; k++) wexp_q.push_back('{a & 32'hFFFF_FFE0, w[64*k +: 64]});
      sb_q.push_back('{w, c0 + 5});
      wait_resp(20);
   endtask

   initial begin
      logic [255:0] wl;
      logic [255:0] rl;
      int c0;
      rst = 1'b1;
      dfp_addr = 32'd0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
      bmem_ready = 1'b0;
      drive_beat(1'b0, 32'd0, 64'd0);
      tick; tick; tick;
      check("rst_dfp_resp",  256'(dfp_resp_o), 256'(1'b0));
      check("rst_dfp_rdata", dfp_rdata_o, 256'd0);
      check("rst_bmem_read", 256'(bmem_read_o), 256'(1'b0));
      check("rst_bmem_write", 256'(bmem_write_o), 256'(1'b0));
      check("rst_bmem_addr", 256'(bmem_addr_o), 256'd0);
      check("rst_bmem_wdata", 256'(bmem_wdata_o), 256'd0);
      rst = 1'b0;
      tick;

      // 1) Minimum-latency read. Beats arrive on cycles 2-5 and resp comes on cycle 6.
      rl = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      read_min(32'h1234_5678, rl, rl);

      // 2) Write with bmem_ready low on cycle 2, so the beats are A,B,B,C,D and resp comes on cycle 6.
      wl = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
            64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
      c0 = cyc;
      dfp_addr = 32'h8000_0040; dfp_wdata = wl; dfp_write = 1'b1; bmem_ready = 1'b1;
      wexp_q.push_back('{32'h8000_0040, wl[63:0]});
      wexp_q.push_back('{32'h8000_0040, wl[127:64]});
      wexp_q.push_back('{32'h8000_0040, wl[127:64]});
      wexp_q.push_back('{32'h8000_0040, wl[191:128]});
      wexp_q.push_back('{32'h8000_0040, wl[255:192]});
      sb_q.push_back('{wl, c0 + 6});
      tick;                      // cycle 1
      tick; bmem_ready = 1'b0;   // cycle 2
      tick; bmem_ready = 1'b1;   // cycle 3
      wait_resp(20);

      // 3) Gapped read. There is a stray rvalid in RD_REQ and a stray raddr mid-burst. Resp comes on cycle 9.
      rl = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
            64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
      c0 = cyc;
      dfp_addr = 32'h0000_101F; dfp_read = 1'b1; bmem_ready = 1'b1;
      sb_q.push_back('{rl, c0 + 9});
      rdaddr_q.push_back(32'h0000_1000);
      tick; drive_beat(1'b1, 32'h0000_1000, 64'hDEAD_BEEF_DEAD_BEEF);  // 1: ignored
      tick; drive_beat(1'b1, 32'h0000_1000, rl[63:0]);                 // 2
      tick; drive_beat(1'b0, 32'h0000_1000, 64'hFFFF_FFFF_FFFF_FFFF);  // 3
      tick; drive_beat(1'b1, 32'h0000_0020, 64'hBAD0_BAD0_BAD0_BAD0);  // 4: stray
      tick; drive_beat(1'b1, 32'h0000_1000, rl[127:64]);               // 5
      tick; drive_beat(1'b1, 32'h0000_1000, rl[191:128]);              // 6
      tick; drive_beat(1'b0, 32'h0000_1000, 64'd0);                    // 7
      tick; drive_beat(1'b1, 32'h0000_1000, rl[255:192]);              // 8
      tick; drive_beat(1'b0, 32'd0, 64'd0);                            // 9
      wait_resp(20);

      // 4) Read and write asserted together. Only the write burst is issued.
      write_full(32'h0000_2000,
                 {64'h0000_0000_2222_0004, 64'h0000_0000_2222_0003,
                  64'h0000_0000_2222_0002, 64'h0000_0000_2222_0001}, 1'b1);

      // 5) Reset during write beat 2. Expect all outputs 0 next cycle and no resp.
      wl = {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
            64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001};
      dfp_addr = 32'h0000_3000; dfp_wdata = wl; dfp_write = 1'b1; bmem_ready = 1'b1;
      wexp_q.push_back('{32'h0000_3000, wl[63:0]});
      wexp_q.push_back('{32'h0000_3000, wl[127:64]});
      wexp_q.push_back('{32'h0000_3000, wl[191:128]});
      tick; tick; tick;          // cycle 3: beat 2 on the bus
      rst = 1'b1; dfp_write = 1'b0;
      tick;
      check("abort_dfp_resp",  256'(dfp_resp_o), 256'(1'b0));
      check("abort_dfp_rdata", dfp_rdata_o, 256'd0);
      check("abort_bmem_read", 256'(bmem_read_o), 256'(1'b0));
      check("abort_bmem_write", 256'(bmem_write_o), 256'(1'b0));
      check("abort_bmem_addr", 256'(bmem_addr_o), 256'd0);
      check("abort_bmem_wdata", 256'(bmem_wdata_o), 256'd0);
      rst = 1'b0;
      rl = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
            64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};
      read_min(32'h0000_3008, rl, rl);

      // 6) Back-to-back write then read to the same line. The read returns the written data.
      wl = {64'h6666_7777_8888_0004, 64'h6666_7777_8888_0003,
            64'h6666_7777_8888_0002, 64'h6666_7777_8888_0001};
      write_full(32'h0000_4010, wl, 1'b0);
      rl = {mem_beats[3], mem_beats[2], mem_beats[1], mem_beats[0]};
      read_min(32'h0000_4000, rl, wl);

      tick; tick;
      check("sb_drained", 256'(sb_q.size()), 256'd0);
      check("wbeats_drained", 256'(wexp_q.size()), 256'd0);
      check("rdaddr_drained", 256'(rdaddr_q.size()), 256'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
